// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One bit is consumed per clock; the result is held on bcd until the next conversion completes.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3   // 10**DIGITS must exceed 2**WIDTH-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [1:0]            dbg_state_o
);

  // Handshake: start is taken on a rising edge only while ready=1, and bin is
  // captured on that same edge. valid is a one-cycle pulse that marks bcd as new;
  // it has no back-pressure, and bcd holds its value until the next pulse.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    valid_d   = 1'b0;
    adj       = scratch_q;

    // Any digit >= 5 would overflow past 9 when doubled, so pre-correct it by 3.
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = scratch_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready       = (state_q == IDLE);
  assign valid       = valid_q;
  assign bcd         = bcd_q;
  assign dbg_state_o = state_q;

endmodule
